// File: rtl/spi_minion_stream.sv
// spi_minion_stream
//   SPI minion front end (mode 0, MSB first) in front of the SPI-facing port
//   of the tape-in interconnect. The pad-level cs/sclk/mosi are oversampled in
//   the clk domain. Fixed-length frames of N+2 bits are turned into a val/rdy
//   message stream, and messages from the interconnect are returned on miso.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   cs, sclk, mosi        : SPI pads (asynchronous to clk, cs active low)
//   miso                  : SPI serial data back to the host
//   send_msg/val/rdy      : inbound stream (SPI host -> interconnect), 2-deep FIFO
//   recv_msg/val/rdy      : outbound stream (interconnect -> SPI host), 1 entry
//   minion_parity         : XOR-reduction of the last payload pushed inbound
//
// Host frame  (mosi): {wr_val, rd_rdy, payload[N-1:0]}
// Minion frame(miso): {space,  rd_val, hold[N-1:0]}, snapshotted on cs fall
module spi_minion_stream #(
  parameter int N = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         sclk,
  input  logic         mosi,
  output logic         miso,
  output logic [N-1:0] send_msg,
  output logic         send_val,
  input  logic         send_rdy,
  input  logic [N-1:0] recv_msg,
  input  logic         recv_val,
  output logic         recv_rdy,
  output logic         minion_parity
);

  localparam int FL = N + 2;               // frame length in bits
  localparam int CW = $clog2(FL + 1);      // bit counter width (0..FL)
  localparam logic [CW-1:0] FULL_CNT = CW'(FL);

  // ---------------------------------------------------------------------------
  // Synchronizers: two flops each, plus a third flop on cs/sclk for edges.
  // ---------------------------------------------------------------------------
  logic cs_meta_reg,   cs_sync_reg,   cs_prev_reg;
  logic sclk_meta_reg, sclk_sync_reg, sclk_prev_reg;
  logic mosi_meta_reg, mosi_sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta_reg   <= 1'b0;
      cs_sync_reg   <= 1'b0;
      cs_prev_reg   <= 1'b0;
      sclk_meta_reg <= 1'b0;
      sclk_sync_reg <= 1'b0;
      sclk_prev_reg <= 1'b0;
      mosi_meta_reg <= 1'b0;
      mosi_sync_reg <= 1'b0;
    end else begin
      cs_meta_reg   <= cs;
      cs_sync_reg   <= cs_meta_reg;
      cs_prev_reg   <= cs_sync_reg;
      sclk_meta_reg <= sclk;
      sclk_sync_reg <= sclk_meta_reg;
      sclk_prev_reg <= sclk_sync_reg;
      mosi_meta_reg <= mosi;
      mosi_sync_reg <= mosi_meta_reg;
    end
  end

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  assign cs_fall   =  cs_prev_reg   & ~cs_sync_reg;
  assign cs_rise   = ~cs_prev_reg   &  cs_sync_reg;
  assign sclk_rise = ~sclk_prev_reg &  sclk_sync_reg;
  assign sclk_fall =  sclk_prev_reg & ~sclk_sync_reg;

  // ---------------------------------------------------------------------------
  // Frame engine
  // frame_active_reg is set only by a cs fall. Reset clears it, so the
  // remaining edges of an aborted frame are ignored until a fresh cs fall.
  // ---------------------------------------------------------------------------
  logic          frame_active_reg;
  logic [CW-1:0] bit_cnt_reg;
  logic [FL-1:0] rx_shift_reg;
  logic [FL-1:0] tx_shift_reg;
  logic          space_snap_reg;
  logic          rd_val_snap_reg;

  logic [1:0]    count_reg;
  logic          hold_full_reg;
  logic [N-1:0]  hold_reg;

  logic space_now;
  assign space_now = (count_reg < 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_active_reg <= 1'b0;
      bit_cnt_reg      <= '0;
      rx_shift_reg     <= '0;
      tx_shift_reg     <= '0;
      space_snap_reg   <= 1'b0;
      rd_val_snap_reg  <= 1'b0;
    end else if (cs_fall) begin
      frame_active_reg <= 1'b1;
      bit_cnt_reg      <= '0;
      tx_shift_reg     <= {space_now, hold_full_reg, hold_reg};
      space_snap_reg   <= space_now;
      rd_val_snap_reg  <= hold_full_reg;
    end else if (cs_rise) begin
      frame_active_reg <= 1'b0;
    end else if (frame_active_reg) begin
      // Extra clocks beyond the frame length are not shifted in, so an
      // over-long frame keeps its first FL bits.
      if (sclk_rise && bit_cnt_reg != FULL_CNT) begin
        rx_shift_reg <= {rx_shift_reg[FL-2:0], mosi_sync_reg};
        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
      end
      if (sclk_fall) begin
        tx_shift_reg <= {tx_shift_reg[FL-2:0], 1'b0};
      end
    end
  end

  // The frame is only honoured when it was opened by a cs fall and carried
  // exactly FL bits; anything else is discarded without side effects.
  logic frame_done, do_push, do_clear, do_pop;
  assign frame_done = cs_rise & frame_active_reg & (bit_cnt_reg == FULL_CNT);
  assign do_push    = frame_done & rx_shift_reg[FL-1] & space_snap_reg;
  assign do_clear   = frame_done & rx_shift_reg[FL-2] & rd_val_snap_reg;
  assign do_pop     = send_val & send_rdy;

  assign miso = frame_active_reg & ~cs_sync_reg & tx_shift_reg[FL-1];

  // ---------------------------------------------------------------------------
  // Inbound FIFO, depth 2. Space is reserved at frame start and the count
  // can only fall during a frame, so a push never meets a full FIFO.
  // ---------------------------------------------------------------------------
  logic         wr_ptr_reg, rd_ptr_reg;
  logic [N-1:0] fifo_mem [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          fifo_mem[gi] <= '0;
        end else if (do_push && wr_ptr_reg == 1'(gi)) begin
          fifo_mem[gi] <= rx_shift_reg[N-1:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
      minion_parity <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg    <= ~wr_ptr_reg;
        minion_parity <= ^rx_shift_reg[N-1:0];
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign send_val = (count_reg != 2'd0);
  assign send_msg = fifo_mem[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Outbound holding register. Load needs empty and clear needs full, so the
  // two never happen in the same cycle. Only the full flag is cleared; the
  // data simply becomes stale.
  // ---------------------------------------------------------------------------
  logic hold_load;
  assign recv_rdy  = ~hold_full_reg;
  assign hold_load = recv_val & ~hold_full_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_reg <= 1'b0;
      hold_reg      <= '0;
    end else if (hold_load) begin
      hold_full_reg <= 1'b1;
      hold_reg      <= recv_msg;
    end else if (do_clear) begin
      hold_full_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_minion_stream.sv
// tb_spi_minion_stream
//   Directed bench for spi_minion_stream. The host side is driven at the
//   falling clk edge with sclk at clk/16. Inbound handshakes are collected by
//   a monitor, and every expected value below is worked out by hand.
module tb_spi_minion_stream;

  localparam int N  = 20;
  localparam int FL = N + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         cs, sclk, mosi;
  logic         miso;
  logic [N-1:0] send_msg;
  logic         send_val;
  logic         send_rdy;
  logic [N-1:0] recv_msg;
  logic         recv_val;
  logic         recv_rdy;
  logic         minion_parity;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] obs_q [$];

  always #5 clk = ~clk;

  spi_minion_stream #(.N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .cs            (cs),
    .sclk          (sclk),
    .mosi          (mosi),
    .miso          (miso),
    .send_msg      (send_msg),
    .send_val      (send_val),
    .send_rdy      (send_rdy),
    .recv_msg      (recv_msg),
    .recv_val      (recv_val),
    .recv_rdy      (recv_rdy),
    .minion_parity (minion_parity)
  );

  // Record each inbound handshake; it completes at the following posedge.
  always @(negedge clk) begin
    if (send_val && send_rdy) begin
      obs_q.push_back(send_msg);
      $display("send handshake msg=%05h", send_msg);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI transaction with nbits clocks. miso is sampled just before each
  // sclk rise. When abort_at >= 0, reset is pulsed before bit abort_at.
  task automatic spi_xfer(input int nbits, input int abort_at,
                          input logic [FL-1:0] tx, output logic [FL-1:0] rx);
    rx = '0;
    cs = 1'b0;
    wait_clks(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(1);
        check("abort_miso", 32'(miso), 32'd0);
      end
      mosi = tx[FL-1-i];
      wait_clks(4);
      rx[FL-1-i] = miso;
      sclk = 1'b1;
      wait_clks(8);
      sclk = 1'b0;
      wait_clks(4);
    end
    wait_clks(4);
    cs   = 1'b1;
    mosi = 1'b0;
    wait_clks(10);
    $display("spi frame bits=%0d tx=%06h rx=%06h", nbits, tx, rx);
  endtask

  logic [FL-1:0] rx;

  initial begin
    reset    = 1'b1;
    cs       = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    send_rdy = 1'b0;
    recv_val = 1'b0;
    recv_msg = '0;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(4);

    // Reset state
    check("rst_send_val", 32'(send_val), 32'd0);
    check("rst_send_msg", 32'(send_msg), 32'd0);
    check("rst_recv_rdy", 32'(recv_rdy), 32'd1);
    check("rst_miso",     32'(miso),     32'd0);
    check("rst_parity",   32'(minion_parity), 32'd0);

    // Single write: 0x5A5A5 has 10 ones -> parity 0
    send_rdy = 1'b1;
    obs_q.delete();
    spi_xfer(FL, -1, {1'b1, 1'b0, 20'h5A5A5}, rx);
    check("wr_snapshot", 32'(rx), 32'({1'b1, 1'b0, 20'h00000}));
    check("wr_count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() >= 1) check("wr_msg", 32'(obs_q[0]), 32'h5A5A5);
    check("wr_parity", 32'(minion_parity), 32'd0);
    check("wr_send_val", 32'(send_val), 32'd0);

    // Read through the holding register
    recv_msg = 20'hABCDE;
    recv_val = 1'b1;
    wait_clks(1);
    recv_val = 1'b0;
    wait_clks(1);
    check("rd_recv_rdy_low", 32'(recv_rdy), 32'd0);
    spi_xfer(FL, -1, {1'b0, 1'b1, 20'h00000}, rx);
    check("rd_snapshot", 32'(rx), 32'({1'b1, 1'b1, 20'hABCDE}));
    check("rd_recv_rdy_high", 32'(recv_rdy), 32'd1);
    spi_xfer(FL, -1, {1'b0, 1'b1, 20'h00000}, rx);
    check("rd2_flags", 32'(rx[FL-1:FL-2]), 32'b10);

    // Backpressure: third write sees space=0 and is dropped
    send_rdy = 1'b0;
    obs_q.delete();
    spi_xfer(FL, -1, {1'b1, 1'b0, 20'h00001}, rx);
    check("bp1_space", 32'(rx[FL-1]), 32'd1);
    check("bp1_parity", 32'(minion_parity), 32'd1);
    spi_xfer(FL, -1, {1'b1, 1'b0, 20'h00002}, rx);
    check("bp2_space", 32'(rx[FL-1]), 32'd1);
    spi_xfer(FL, -1, {1'b1, 1'b0, 20'h00003}, rx);
    check("bp3_space", 32'(rx[FL-1]), 32'd0);
    check("bp3_parity_kept", 32'(minion_parity), 32'd1);
    check("bp_send_val", 32'(send_val), 32'd1);
    check("bp_head", 32'(send_msg), 32'h00001);
    check("bp_no_early_pop", 32'(obs_q.size()), 32'd0);
    send_rdy = 1'b1;
    wait_clks(6);
    check("bp_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() >= 2) begin
      check("bp_first",  32'(obs_q[0]), 32'h00001);
      check("bp_second", 32'(obs_q[1]), 32'h00002);
    end
    check("bp_drained", 32'(send_val), 32'd0);

    // Short frame: 15 bits, payload 0x00003 would clear parity if accepted
    obs_q.delete();
    spi_xfer(15, -1, {1'b1, 1'b0, 20'h00003}, rx);
    check("short_no_push", 32'(obs_q.size()), 32'd0);
    check("short_parity", 32'(minion_parity), 32'd1);
    spi_xfer(FL, -1, {1'b1, 1'b0, 20'h0000F}, rx);
    check("after_short_count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() >= 1) check("after_short_msg", 32'(obs_q[0]), 32'h0000F);
    check("after_short_parity", 32'(minion_parity), 32'd0);

    // Reset mid-frame after 10 bits; the remaining edges must be ignored
    obs_q.delete();
    spi_xfer(FL, 10, {1'b1, 1'b0, 20'hFFFFE}, rx);
    check("abort_rx_tail", 32'(rx[11:0]), 32'd0);
    check("abort_no_push", 32'(obs_q.size()), 32'd0);
    check("abort_parity", 32'(minion_parity), 32'd0);
    check("abort_recv_rdy", 32'(recv_rdy), 32'd1);
    // 0x12345 has 7 ones -> parity 1
    spi_xfer(FL, -1, {1'b1, 1'b0, 20'h12345}, rx);
    check("post_abort_flags", 32'(rx[FL-1:FL-2]), 32'b10);
    check("post_abort_count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() >= 1) check("post_abort_msg", 32'(obs_q[0]), 32'h12345);
    check("post_abort_parity", 32'(minion_parity), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_minion_stream.md
# spi_minion_stream

SPI minion front end that sits directly upstream of the SPI-facing port of the tape-in interconnect. It oversamples the pad-level `cs`/`sclk`/`mosi` in the `clk` domain and converts fixed-length SPI frames into a val/rdy message stream toward the interconnect. It also returns interconnect messages to the SPI host on `miso`, and drives `minion_parity` from each accepted inbound payload.

## Interface
- `N`, 20: payload width in bits. The frame length is N+2 bits.
- `clk`  in  1: system clock, the only clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `cs`  in  1: SPI chip select, active low, asynchronous to `clk`.
- `sclk`  in  1: SPI clock, asynchronous to `clk`. Must satisfy f_sclk ≤ f_clk/8.
- `mosi`  in  1: host-to-minion serial data.
- `miso`  out  1: minion-to-host serial data.
- `send_msg`  out  N: inbound payload toward the interconnect.
- `send_val`  out  1: `send_msg` is valid.
- `send_rdy`  in  1: the interconnect accepts `send_msg`.
- `recv_msg`  in  N: outbound payload from the interconnect.
- `recv_val`  in  1: `recv_msg` is valid.
- `recv_rdy`  out  1: the minion accepts `recv_msg`.
- `minion_parity`  out  1: XOR-reduction of the last payload pushed into the inbound FIFO.

## Operation
- **Synchronizers**
  - `cs`, `sclk` and `mosi` each pass through a 2-flop synchronizer.
  - A third flop on `cs` and `sclk` provides edge detection. Only synchronized signals are used internally.
- **SPI mode 0, MSB first**
  - `mosi` is sampled on the synchronized `sclk` rise.
  - `miso` shifts on the synchronized `sclk` fall.
  - Edges are ignored while synchronized `cs` is high.
- **Host frame (mosi)**, N+2 bits: `{wr_val, rd_rdy, payload[N-1:0]}`.
- **Minion frame (miso)**, N+2 bits: `{space, rd_val, hold[N-1:0]}`. It is snapshotted on the synchronized `cs` fall:
  - `space` = inbound FIFO count < 2.
  - `rd_val` = holding register full.
  - The first bit is driven on `miso` at that same cycle.
- **Bit counter**
  - 0 to N+2. Cleared on `cs` fall, incremented per `sclk` rise, saturating at N+2.
- **Frame end** (synchronized `cs` rise) with bit count == N+2:
  - If `wr_val` and snapshot `space`: push `payload` into the inbound FIFO and set `minion_parity` = ^`payload`.
  - If `wr_val` and not `space`: the write is dropped.
  - If `rd_rdy` and snapshot `rd_val`: clear the holding register.
- **Frame end** with bit count ≠ N+2: the frame is discarded. No push, no pop, and `minion_parity` is unchanged.
- **Inbound FIFO**
  - Depth 2, oldest entry at the head.
  - `send_val` = count ≠ 0 and `send_msg` = head.
  - Pops on `send_val && send_rdy`.
  - Push and pop in the same cycle are both performed, leaving the count unchanged.
  - `space` is sampled at frame start. During a frame the count can only fall, so the reserved slot is always available at frame end.
- **Holding register** (outbound, 1 entry)
  - `recv_rdy` = holding empty. It loads `recv_msg` on `recv_val && recv_rdy`.
  - A load during a frame does not change that frame's snapshot.
  - A load and a frame-end clear cannot coincide, because a clear requires full and a load requires empty.
- **`miso`** is 0 whenever synchronized `cs` is high.
- **`reset`**
  - Clears the synchronizers, bit counter, FIFO, holding register and shift registers.
  - A frame in progress is aborted. The remaining edges of that frame are ignored until the next `cs` fall.

## Timing
- Reset values: `send_val`=0, `send_msg`=0, `recv_rdy`=1, `miso`=0, `minion_parity`=0.
- Pad edge first sampled at `clk` edge k → the internal action is registered at edge k+2.
- A push on `cs` rise makes `send_val`=1 visible after edge k+2.
- `miso` changes after edge k+2, where k is the sampling edge of the `sclk` fall.
- `miso` on `cs` fall: the first frame bit is valid after edge k+2, well before the first `sclk` rise given f_sclk ≤ f_clk/8.
- `recv_rdy` deasserts the cycle after a load. It reasserts the cycle after a frame-end clear.
- `send_val` drops the cycle after the pop of the last entry.
- FIFO full (2 entries) with `send_rdy`=0: `space`=0 in every subsequent snapshot until a pop.

## Test plan
- **Reset:** assert `reset` 2 cycles → `send_val`=0, `recv_rdy`=1, `miso`=0, `minion_parity`=0.
- **Single write:** N=20, `send_rdy`=1, host frame `{1,0,0x5A5A5}` → exactly one `send_msg`=0x5A5A5 handshake; `minion_parity`=0 (10 ones); minion frame reads `space`=1, `rd_val`=0.
- **Read:** drive `recv_msg`=0xABCDE with `recv_val` → `recv_rdy` falls. Host frame `{0,1,0}` → `miso` shifts `{space=1,1,0xABCDE}`; `recv_rdy`=1 after frame end. A second read returns `rd_val`=0.
- **Backpressure:** `send_rdy`=0, three write frames 0x00001/0x00002/0x00003 → third frame reads `space`=0 and is dropped. Then `send_rdy`=1 → handshakes 0x00001 then 0x00002 only.
- **Short frame:** `cs` rises after 15 bits with `wr_val`=1 → no push, `minion_parity` unchanged. The next full frame works normally.
- **Reset mid-frame:** assert `reset` after 10 bits → no push, `miso`=0. The next complete frame is accepted.
